rip_tournament_predictor: RTL
=============================

RIP_TOURNAMENT_PREDICTOR -- requirements
Module: rip_tournament_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 10, meaning the address width of every table (2^IDX_W entries each).
REQ-002 SHALL have parameter PC_LSB, default 2, meaning the lowest PC bit used for indexing.
REQ-003 SHALL have parameter HIST_LEN, default 10, meaning global history length; legal range 1..IDX_W.
REQ-004 SHALL have parameter CTR_W, default 2, meaning the saturating counter width; legal range 2..4.
REQ-005 SHALL define META_W = 3*CTR_W + HIST_LEN.
REQ-006 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- ready  out  1  table initialisation complete.
- req_valid  in  1  prediction request.
- req_pc  in  32  PC of the request.
- pred_valid  out  1  prediction valid.
- pred_taken  out  1  final prediction.
- pred_meta  out  META_W  {chooser_ctr, gsh_ctr, bim_ctr, hist_snapshot}, MSB first.
- upd_valid  in  1  resolve/update strobe.
- upd_pc  in  32  PC of the resolved branch.
- upd_meta  in  META_W  pred_meta returned unchanged.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  final prediction was wrong.

Function
REQ-007 SHALL index as follows: bim_idx = pc[PC_LSB+IDX_W-1:PC_LSB]; gsh_idx = bim_idx XOR zero-extended hist. The chooser uses bim_idx.
REQ-008 SHALL implement three tables (bimodal, gshare, chooser) with synchronous read, one write port each, and read-first ordering on same-address read/write.
REQ-009 SHALL treat a counter as taken when ctr >= 2^(CTR_W-1).
REQ-010 SHALL update counters as saturating: increment stops at 2^CTR_W-1; decrement stops at 0.
REQ-011 SHALL apply a 1-cycle latency: req_valid in cycle N gives pred_valid=1 in cycle N+1 with the counters read at the cycle-N indices.
REQ-012 SHALL compute pred_taken = gshare taken if chooser is taken, else bimodal taken.
REQ-013 SHALL place in pred_meta.hist_snapshot the history used to form gsh_idx.
REQ-014 SHALL shift history speculatively when pred_valid=1: hist <= {hist[HIST_LEN-2:0], pred_taken}, or hist <= pred_taken when HIST_LEN=1.
REQ-015 SHALL recover history on upd_valid & upd_mispredict: hist <= snapshot shifted with upd_taken. Recovery overrides a same-cycle speculative shift.
REQ-016 SHALL write on upd_valid as follows:
- bimodal[upd bim_idx] <= bim_ctr stepped by upd_taken.
- gshare[upd_pc idx XOR snapshot] <= gsh_ctr stepped by upd_taken.
REQ-017 SHALL write the chooser only when the bimodal and gshare directions in upd_meta differ: increment if gshare matched upd_taken, otherwise decrement.
REQ-018 SHALL carry counter state only through meta. No read-modify-write of the tables is done on update.
REQ-019 SHALL have a two-state FSM: INIT and RUN.
- In INIT, a counter walks 0..2^IDX_W-1, one entry per cycle, writing all tables to 2^(CTR_W-1)-1 (weakly not-taken / weakly bimodal).
- After the last entry the FSM moves to RUN and ready=1 from the next cycle.
REQ-020 SHALL ignore req_valid and upd_valid in INIT; pred_valid stays 0.
REQ-021 SHALL behave in RUN with simultaneous request and update (same or different index) as read-first, with both completing.
REQ-022 SHALL leave pred_taken and pred_meta at their last values when pred_valid=0.

Reset
REQ-023 SHALL, while rst=1, force ready=0, pred_valid=0, pred_taken=0, pred_meta=0, hist=0, FSM=INIT, init counter=0. Table contents are undefined until INIT completes.
REQ-024 SHALL, on rst asserted mid-operation, drop ready in the same cycle (asynchronously) and fully re-run INIT after deassertion.

Verification
All scenarios use IDX_W=4, PC_LSB=2, HIST_LEN=4, CTR_W=2.
REQ-025 Release rst -> ready=1 exactly 17 cycles later; req_pc=0x40 -> pred_valid next cycle, pred_taken=0, bim/gsh/chooser=1.
REQ-026 Two upd_valid, upd_pc=0x40, upd_taken=1, with meta bim=1 then 2 -> bimodal[0] reads 3. Chooser stays 1 because gsh and bim directions agreed.
REQ-027 Update with bim=3, taken=1 -> stays 3; update with bim=0, taken=0 -> stays 0.
REQ-028 Four predictions with pred_taken=0 -> hist=0000. Then upd_mispredict, snapshot=0101, upd_taken=1, in the same cycle as a pred_valid -> hist=1011 next cycle; the speculative shift is discarded.
REQ-029 Update with bim=1, gsh=2, chooser=1, upd_taken=1 -> chooser becomes 2, and the next prediction at that PC uses gshare.
REQ-030 Assert rst during RUN with hist=1011 -> ready=0 and hist=0 immediately; 16 INIT writes occur after release; all counters are back at 1.

Source files
------------

// File: rtl/rip_tournament_predictor.sv
// rtl/rip_tournament_predictor.sv - tournament branch predictor (bimodal + gshare + chooser)
module rip_tournament_predictor #(
   parameter int IDX_W    = 10,
   parameter int PC_LSB   = 2,
   parameter int HIST_LEN = 10,
   parameter int CTR_W    = 2,
   localparam int META_W  = 3*CTR_W + HIST_LEN
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   input  logic              req_valid,
   input  logic [31:0]       req_pc,
   output logic              pred_valid,
   output logic              pred_taken,
   output logic [META_W-1:0] pred_meta,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic [META_W-1:0] upd_meta,
   input  logic              upd_taken,
   input  logic              upd_mispredict
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W-1)) - 1);
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t           state_q;
   logic [IDX_W-1:0] init_q;
   logic             ready_q;

   logic [CTR_W-1:0] bim_mem [ENTRIES];
   logic [CTR_W-1:0] gsh_mem [ENTRIES];
   logic [CTR_W-1:0] cho_mem [ENTRIES];

   logic                pred_valid_q;
   logic [CTR_W-1:0]    bim_rd_q, gsh_rd_q, cho_rd_q;
   logic [HIST_LEN-1:0] snap_q;
   logic [HIST_LEN-1:0] hist_q, hist_d;

   function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
      if (up) return (c == CTR_MAX) ? c : c + CTR_W'(1);
      return (c == '0) ? c : c - CTR_W'(1);
   endfunction

   function automatic logic [HIST_LEN-1:0] hist_push(input logic [HIST_LEN-1:0] h, input logic b);
      logic [HIST_LEN:0] w;
      w = {h, b};
      return w[HIST_LEN-1:0];
   endfunction

   logic run, req_fire, upd_fire;
   assign run      = (state_q == S_RUN);
   assign req_fire = req_valid & run;
   assign upd_fire = upd_valid & run;

   logic [IDX_W-1:0] req_bim_idx, req_gsh_idx;
   assign req_bim_idx = req_pc[PC_LSB +: IDX_W];
   assign req_gsh_idx = req_bim_idx ^ IDX_W'(hist_q);

   logic [CTR_W-1:0]    upd_cho, upd_gsh, upd_bim;
   logic [HIST_LEN-1:0] upd_hist;
   logic [IDX_W-1:0]    upd_bim_idx, upd_gsh_idx;
   logic                upd_bim_dir, upd_gsh_dir;
   assign upd_cho     = upd_meta[META_W-1 -: CTR_W];
   assign upd_gsh     = upd_meta[META_W-CTR_W-1 -: CTR_W];
   assign upd_bim     = upd_meta[HIST_LEN +: CTR_W];
   assign upd_hist    = upd_meta[HIST_LEN-1:0];
   assign upd_bim_idx = upd_pc[PC_LSB +: IDX_W];
   assign upd_gsh_idx = upd_bim_idx ^ IDX_W'(upd_hist);
   assign upd_bim_dir = upd_bim[CTR_W-1];
   assign upd_gsh_dir = upd_gsh[CTR_W-1];

   logic unused_pc_bits;
   assign unused_pc_bits = ^{req_pc, upd_pc};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_INIT;
         init_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= (state_q == S_RUN);
         if (state_q == S_INIT) begin
            init_q <= init_q + IDX_W'(1);
            if (init_q == '1) state_q <= S_RUN;
         end
      end
   end

   // During INIT the write ports are owned by the walker; updates only write in RUN.
   logic             bim_we, gsh_we, cho_we;
   logic [IDX_W-1:0] bim_waddr, gsh_waddr, cho_waddr;
   logic [CTR_W-1:0] bim_wdata, gsh_wdata, cho_wdata;

   always_comb begin
      bim_we    = 1'b0;
      gsh_we    = 1'b0;
      cho_we    = 1'b0;
      bim_waddr = init_q;
      gsh_waddr = init_q;
      cho_waddr = init_q;
      bim_wdata = CTR_INIT;
      gsh_wdata = CTR_INIT;
      cho_wdata = CTR_INIT;
      if (state_q == S_INIT) begin
         bim_we = 1'b1;
         gsh_we = 1'b1;
         cho_we = 1'b1;
      end else begin
         bim_we    = upd_fire;
         bim_waddr = upd_bim_idx;
         bim_wdata = ctr_step(upd_bim, upd_taken);
         gsh_we    = upd_fire;
         gsh_waddr = upd_gsh_idx;
         gsh_wdata = ctr_step(upd_gsh, upd_taken);
         cho_we    = upd_fire & (upd_bim_dir != upd_gsh_dir);
         cho_waddr = upd_bim_idx;
         cho_wdata = ctr_step(upd_cho, upd_gsh_dir == upd_taken);
      end
   end

   always_ff @(posedge clk) begin
      if (bim_we) bim_mem[bim_waddr] <= bim_wdata;
      if (gsh_we) gsh_mem[gsh_waddr] <= gsh_wdata;
      if (cho_we) cho_mem[cho_waddr] <= cho_wdata;
   end

   assign pred_taken = cho_rd_q[CTR_W-1] ? gsh_rd_q[CTR_W-1] : bim_rd_q[CTR_W-1];

   // Misprediction recovery wins over the speculative shift of the current prediction.
   always_comb begin
      hist_d = hist_q;
      if (upd_fire && upd_mispredict) hist_d = hist_push(upd_hist, upd_taken);
      else if (pred_valid_q)          hist_d = hist_push(hist_q, pred_taken);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pred_valid_q <= 1'b0;
         bim_rd_q     <= '0;
         gsh_rd_q     <= '0;
         cho_rd_q     <= '0;
         snap_q       <= '0;
         hist_q       <= '0;
      end else begin
         pred_valid_q <= req_fire;
         hist_q       <= hist_d;
         if (req_fire) begin
            bim_rd_q <= bim_mem[req_bim_idx];
            gsh_rd_q <= gsh_mem[req_gsh_idx];
            cho_rd_q <= cho_mem[req_bim_idx];
            snap_q   <= hist_q;
         end
      end
   end

   assign ready      = ready_q;
   assign pred_valid = pred_valid_q;
   assign pred_meta  = {cho_rd_q, gsh_rd_q, bim_rd_q, snap_q};

endmodule
